// File: rtl/adbg_ahb3_xfer.sv
// AHB3-Lite master transfer engine for the AHB3 debug module: runs one request at a
// time on the bus, handling wait states, ERROR responses, lane steering and 64-bit splits.
module adbg_ahb3_xfer #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  req_i,
  output logic                  req_ack_o,
  input  logic                  req_we_i,
  input  logic [HADDR_SIZE-1:0] req_addr_i,
  input  logic [2:0]            req_size_i,
  input  logic [63:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [63:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  busy_o,
  output logic [2:0]            dbg_state_o,
  output logic                  HSEL,
  output logic [HADDR_SIZE-1:0] HADDR,
  output logic [HDATA_SIZE-1:0] HWDATA,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [1:0]            HTRANS,
  output logic                  HMASTLOCK,
  input  logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  localparam int LANE_BITS = $clog2(HDATA_SIZE / 8);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HSIZE_32      = 3'b010;
  localparam logic [2:0] HSIZE_64      = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHECK     = 3'd1,
    ST_ADDR      = 3'd2,
    ST_ADDR_DATA = 3'd3,
    ST_DATA      = 3'd4,
    ST_RESP      = 3'd5
  } state_t;

  state_t                  r_state;
  logic                    r_we;
  logic [HADDR_SIZE-1:0]   r_addr;
  logic [2:0]              r_size;
  logic [63:0]             r_wdata;
  logic                    r_err;
  logic [31:0]             r_rd_lo;
  logic [63:0]             r_rdata_out;
  logic                    r_hsel;
  logic [HADDR_SIZE-1:0]   r_haddr;
  logic [HDATA_SIZE-1:0]   r_hwdata;
  logic                    r_hwrite;
  logic [2:0]              r_hsize;
  logic [2:0]              r_hburst;
  logic [1:0]              r_htrans;

  logic                    w_two_beat;
  logic                    w_misaligned;
  logic [63:0]             w_size_mask;
  logic [LANE_BITS+2:0]    w_shamt;
  logic [63:0]             w_wdata_m;
  logic [HDATA_SIZE-1:0]   w_beat1_wdata;
  logic [HDATA_SIZE-1:0]   w_beat2_wdata;
  logic [63:0]             w_rd_lane;
  logic [63:0]             w_rd_final;
  logic                    w_rd_kill;

  assign w_two_beat = (r_size == HSIZE_64) && (HDATA_SIZE == 32);
  assign w_shamt    = {r_addr[LANE_BITS-1:0], 3'b000};

  always_comb begin
    w_misaligned = 1'b0;
    w_size_mask  = 64'hFFFF_FFFF_FFFF_FFFF;
    case (r_size)
      3'd0: w_size_mask = 64'h0000_0000_0000_00FF;
      3'd1: begin
        w_size_mask  = 64'h0000_0000_0000_FFFF;
        w_misaligned = r_addr[0];
      end
      3'd2: begin
        w_size_mask  = 64'h0000_0000_FFFF_FFFF;
        w_misaligned = |r_addr[1:0];
      end
      3'd3: w_misaligned = |r_addr[2:0];
      default: w_misaligned = 1'b1;
    endcase
  end

  // A split access is 8-byte aligned, so both beats sit in lane 0 and the
  // second beat carries the upper word.
  assign w_wdata_m     = r_wdata & w_size_mask;
  assign w_beat1_wdata = HDATA_SIZE'(w_wdata_m << w_shamt);
  assign w_beat2_wdata = HDATA_SIZE'(w_wdata_m >> 32);
  assign w_rd_lane     = 64'(HRDATA >> w_shamt) & w_size_mask;
  assign w_rd_final    = w_two_beat ? {w_rd_lane[31:0], r_rd_lo} : w_rd_lane;
  assign w_rd_kill     = r_we | r_err | HRESP;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_size      <= '0;
      r_wdata     <= '0;
      r_err       <= 1'b0;
      r_rd_lo     <= '0;
      r_rdata_out <= '0;
      r_hsel      <= 1'b0;
      r_haddr     <= '0;
      r_hwdata    <= '0;
      r_hwrite    <= 1'b0;
      r_hsize     <= '0;
      r_hburst    <= '0;
      r_htrans    <= HTRANS_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_i) begin
            r_we    <= req_we_i;
            r_addr  <= req_addr_i;
            r_size  <= req_size_i;
            r_wdata <= req_wdata_i;
            r_err   <= 1'b0;
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (w_misaligned) begin
            r_err       <= 1'b1;
            r_rdata_out <= '0;
            r_state     <= ST_RESP;
          end else begin
            r_hsel   <= 1'b1;
            r_htrans <= HTRANS_NONSEQ;
            r_haddr  <= r_addr;
            r_hwrite <= r_we;
            r_hsize  <= w_two_beat ? HSIZE_32 : r_size;
            r_hburst <= w_two_beat ? HBURST_INCR : HBURST_SINGLE;
            r_state  <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (HREADY) begin
            r_hwdata <= r_we ? w_beat1_wdata : '0;
            if (w_two_beat) begin
              r_htrans <= HTRANS_SEQ;
              r_haddr  <= r_haddr + HADDR_SIZE'(4);
              r_state  <= ST_ADDR_DATA;
            end else begin
              r_htrans <= HTRANS_IDLE;
              r_hsel   <= 1'b0;
              r_state  <= ST_DATA;
            end
          end
        end
        ST_ADDR_DATA: begin
          // First ERROR cycle: withdraw beat 2 so the bus sees IDLE in the second.
          if (HRESP && !HREADY) begin
            r_err    <= 1'b1;
            r_htrans <= HTRANS_IDLE;
            r_hsel   <= 1'b0;
          end else if (HREADY) begin
            r_htrans <= HTRANS_IDLE;
            r_hsel   <= 1'b0;
            if (r_err || HRESP) begin
              r_rdata_out <= '0;
              r_state     <= ST_RESP;
            end else begin
              r_rd_lo  <= w_rd_lane[31:0];
              r_hwdata <= r_we ? w_beat2_wdata : '0;
              r_state  <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (HRESP && !HREADY) begin
            r_err <= 1'b1;
          end else if (HREADY) begin
            r_rdata_out <= w_rd_kill ? 64'd0 : w_rd_final;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ack_o   = (r_state == ST_IDLE);
  assign busy_o      = (r_state != ST_IDLE);
  assign rsp_valid_o = (r_state == ST_RESP);
  assign rsp_err_o   = (r_state == ST_RESP) && r_err;
  assign rsp_rdata_o = r_rdata_out;
  assign dbg_state_o = r_state;

  assign HSEL      = r_hsel;
  assign HADDR     = r_haddr;
  assign HWDATA    = r_hwdata;
  assign HWRITE    = r_hwrite;
  assign HSIZE     = r_hsize;
  assign HBURST    = r_hburst;
  assign HTRANS    = r_htrans;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_adbg_ahb3_xfer.sv
// Directed bench for adbg_ahb3_xfer on a 32-bit bus; the bench plays the AHB slave
// and a scoreboard queue holds the expected {err, rdata} of every request.
module tb_adbg_ahb3_xfer;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic        HCLK;
  logic        HRESET;
  logic        req_i;
  logic        req_ack_o;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [2:0]  req_size_i;
  logic [63:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [63:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        busy_o;
  logic [2:0]  dbg_state_o;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HMASTLOCK;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  int n_checks;
  int n_errors;
  int cyc;
  logic [64:0] exp_q[$];

  adbg_ahb3_xfer #(.HADDR_SIZE(32), .HDATA_SIZE(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_i(req_i), .req_ack_o(req_ack_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_size_i(req_size_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .busy_o(busy_o), .dbg_state_o(dbg_state_o),
    .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  // Clock and watchdog
  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Driver and checker tasks
  task automatic tick();
    @(posedge HCLK);
    @(negedge HCLK);
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic we, input logic [31:0] addr, input logic [2:0] size,
                      input logic [63:0] wdata, input logic exp_err, input logic [63:0] exp_rdata);
    chk("req_ack_idle", 64'(req_ack_o), 64'd1);
    req_i       = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_size_i  = size;
    req_wdata_i = wdata;
    exp_q.push_back({exp_err, exp_rdata});
    cyc = 0;
    tick();
    req_i = 1'b0;
    chk("busy_after_accept", 64'(busy_o), 64'd1);
  endtask

  task automatic wait_rsp(input int exp_cyc);
    logic [64:0] e;
    while (!rsp_valid_o && cyc < 60) tick();
    chk("rsp_valid", 64'(rsp_valid_o), 64'd1);
    chk("rsp_latency", 64'(cyc), 64'(exp_cyc));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rsp_err", 64'(rsp_err_o), 64'(e[64]));
      chk("rsp_rdata", rsp_rdata_o, e[63:0]);
    end else begin
      chk("scoreboard_nonempty", 64'(exp_q.size()), 64'd1);
    end
    tick();
    chk("rsp_valid_pulse", 64'(rsp_valid_o), 64'd0);
    chk("req_ack_after_rsp", 64'(req_ack_o), 64'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_htrans"}, 64'(HTRANS), 64'(T_IDLE));
    chk({tag, "_hsel"}, 64'(HSEL), 64'd0);
    chk({tag, "_haddr"}, 64'(HADDR), 64'd0);
    chk({tag, "_hwdata"}, 64'(HWDATA), 64'd0);
    chk({tag, "_hwrite"}, 64'(HWRITE), 64'd0);
    chk({tag, "_hsize"}, 64'(HSIZE), 64'd0);
    chk({tag, "_hburst"}, 64'(HBURST), 64'd0);
    chk({tag, "_hprot"}, 64'(HPROT), 64'h3);
    chk({tag, "_hmastlock"}, 64'(HMASTLOCK), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata_o, 64'd0);
    chk({tag, "_rsp_err"}, 64'(rsp_err_o), 64'd0);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
  endtask

  // Directed sequence
  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc = 0;
    HRESET = 1'b1;
    req_i = 1'b0;
    req_we_i = 1'b0;
    req_addr_i = '0;
    req_size_i = '0;
    req_wdata_i = '0;
    HRDATA = '0;
    HREADY = 1'b1;
    HRESP = 1'b0;
    @(negedge HCLK);
    tick();
    tick();
    chk_reset_outputs("reset");
    HRESET = 1'b0;
    tick();

    // Aligned 32-bit write, zero wait
    send(1'b1, 32'h100, 3'd2, 64'h0000_0000_DEAD_BEEF, 1'b0, 64'd0);
    chk("w32_c1_htrans", 64'(HTRANS), 64'(T_IDLE));
    tick();
    chk("w32_htrans", 64'(HTRANS), 64'(T_NONSEQ));
    chk("w32_hsel", 64'(HSEL), 64'd1);
    chk("w32_haddr", 64'(HADDR), 64'h100);
    chk("w32_hwrite", 64'(HWRITE), 64'd1);
    chk("w32_hsize", 64'(HSIZE), 64'd2);
    chk("w32_hburst", 64'(HBURST), 64'd0);
    chk("w32_hprot", 64'(HPROT), 64'h3);
    tick();
    chk("w32_data_htrans", 64'(HTRANS), 64'(T_IDLE));
    chk("w32_hwdata", 64'(HWDATA), 64'hDEAD_BEEF);
    wait_rsp(4);

    // Byte write at 0x102 with one address-phase wait
    send(1'b1, 32'h102, 3'd0, 64'h0000_0000_0000_00A5, 1'b0, 64'd0);
    tick();
    HREADY = 1'b0;
    chk("wb_htrans", 64'(HTRANS), 64'(T_NONSEQ));
    tick();
    HREADY = 1'b1;
    chk("wb_hold_htrans", 64'(HTRANS), 64'(T_NONSEQ));
    chk("wb_hold_haddr", 64'(HADDR), 64'h102);
    chk("wb_hold_hsize", 64'(HSIZE), 64'd0);
    chk("wb_hold_hwdata", 64'(HWDATA), 64'hDEAD_BEEF);
    tick();
    chk("wb_hwdata_lane", 64'(HWDATA), 64'h00A5_0000);
    wait_rsp(5);

    // Byte read at 0x103 with two data-phase waits
    send(1'b0, 32'h103, 3'd0, 64'd0, 1'b0, 64'h44);
    tick();
    chk("rb_haddr", 64'(HADDR), 64'h103);
    chk("rb_hwrite", 64'(HWRITE), 64'd0);
    tick();
    HREADY = 1'b0;
    HRDATA = 32'h5555_5555;
    tick();
    tick();
    HREADY = 1'b1;
    HRDATA = 32'h4433_2211;
    wait_rsp(6);

    // Split 64-bit write
    send(1'b1, 32'h200, 3'd3, 64'h1122_3344_5566_7788, 1'b0, 64'd0);
    tick();
    chk("sw_b1_htrans", 64'(HTRANS), 64'(T_NONSEQ));
    chk("sw_b1_haddr", 64'(HADDR), 64'h200);
    chk("sw_b1_hburst", 64'(HBURST), 64'd1);
    chk("sw_b1_hsize", 64'(HSIZE), 64'd2);
    tick();
    chk("sw_b2_htrans", 64'(HTRANS), 64'(T_SEQ));
    chk("sw_b2_haddr", 64'(HADDR), 64'h204);
    chk("sw_b1_hwdata", 64'(HWDATA), 64'h5566_7788);
    tick();
    chk("sw_end_htrans", 64'(HTRANS), 64'(T_IDLE));
    chk("sw_b2_hwdata", 64'(HWDATA), 64'h1122_3344);
    wait_rsp(5);

    // Split 64-bit read, zero wait
    send(1'b0, 32'h300, 3'd3, 64'd0, 1'b0, 64'h0102_0304_AABB_CCDD);
    tick();
    chk("sr_hburst", 64'(HBURST), 64'd1);
    tick();
    HRDATA = 32'hAABB_CCDD;
    tick();
    HRDATA = 32'h0102_0304;
    wait_rsp(5);

    // Error on beat 1 of a split read
    send(1'b0, 32'h208, 3'd3, 64'd0, 1'b1, 64'd0);
    tick();
    tick();
    chk("er_b2_htrans", 64'(HTRANS), 64'(T_SEQ));
    chk("er_b2_haddr", 64'(HADDR), 64'h20C);
    HRESP = 1'b1;
    HREADY = 1'b0;
    HRDATA = 32'hFFFF_FFFF;
    tick();
    chk("er_2nd_htrans", 64'(HTRANS), 64'(T_IDLE));
    chk("er_2nd_hsel", 64'(HSEL), 64'd0);
    HREADY = 1'b1;
    wait_rsp(5);
    HRESP = 1'b0;
    chk("er_no_seq", 64'(HTRANS), 64'(T_IDLE));

    // Misaligned and oversize requests: no bus activity
    send(1'b0, 32'h101, 3'd1, 64'd0, 1'b1, 64'd0);
    chk("mis_c1_htrans", 64'(HTRANS), 64'(T_IDLE));
    tick();
    chk("mis_c2_htrans", 64'(HTRANS), 64'(T_IDLE));
    wait_rsp(2);
    send(1'b0, 32'h0, 3'd4, 64'd0, 1'b1, 64'd0);
    wait_rsp(2);

    // Plain 32-bit read so rsp_rdata_o is non-zero before the reset test
    send(1'b0, 32'h400, 3'd2, 64'd0, 1'b0, 64'hCAFE_F00D);
    HRDATA = 32'hCAFE_F00D;
    wait_rsp(4);

    // Reset mid-transfer while in DATA with HREADY low
    send(1'b1, 32'h404, 3'd2, 64'h0000_0000_1234_5678, 1'b0, 64'd0);
    tick();
    tick();
    HREADY = 1'b0;
    tick();
    HRESET = 1'b1;
    tick();
    chk_reset_outputs("midrst");
    req_i = 1'b1;
    tick();
    chk("rst_prio_busy", 64'(busy_o), 64'd0);
    req_i = 1'b0;
    HRESET = 1'b0;
    HREADY = 1'b1;
    void'(exp_q.pop_back());
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_no_rsp", 64'(rsp_valid_o), 64'd0);
    end
    chk("midrst_req_ack", 64'(req_ack_o), 64'd1);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
